cbus_rr_arbiter: RTL and testbench
==================================

Name: cbus_rr_arbiter

Overview:
- Round-robin arbiter that shares the single external cache-bus port between NUM_REQ requesters. Requester 0 is the instruction-side converter; requester 1 is the data-side converter.
- Replaces the fixed-priority mux at the top level.
- Grants whole transactions. A grant is held from acceptance until the last beat completes, so bursts are never interleaved.
- Priority rotates after every completed transaction, so neither fetch nor memory access can starve.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- IDX_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ireqs  in  NUM_REQ × cbus_req_t  per-requester request (valid, is_write, size, addr, strobe, data, len, burst).
- iresps  out  NUM_REQ × cbus_resp_t  per-requester response (ready, last, data).
- oreq  out  cbus_req_t  request to the memory side.
- oresp  in  cbus_resp_t  response from the memory side.
- busy  out  1  a transaction is granted.
- grant_idx  out  IDX_W  index of the current or most recent grantee.

Behaviour:

Reset (reset = 0, asynchronous):
- state = IDLE, busy = 0, grant_idx = 0, prio_ptr = 0.
- oreq is all-zero and every iresps[i] is all-zero while in reset.

State IDLE:
- oreq = 0 and all iresps = 0; nothing is forwarded.
- Candidate = first i scanning prio_ptr, prio_ptr+1, … modulo NUM_REQ with ireqs[i].valid = 1.
- If a candidate exists: grant_idx ← candidate, state ← BUSY.
- Arbitration latency is exactly 1 cycle. A request asserted in cycle t appears on oreq in cycle t+1.

State BUSY:
- oreq = ireqs[grant_idx], passed through combinationally.
- iresps[grant_idx] = oresp. iresps[j] = 0 for every j ≠ grant_idx.
- Non-granted requesters stay pending. Their valid is held by the requester protocol; the arbiter does not latch it.
- A beat completes on oresp.ready = 1.
- Transaction ends on oresp.ready = 1 AND oresp.last = 1:
  - state ← IDLE;
  - prio_ptr ← (grant_idx + 1) mod NUM_REQ;
  - grant_idx keeps its value.
- Minimum spacing between the end of one transaction and the first oreq.valid of the next is 1 idle cycle. This bubble is intentional and gives a clean bus turnaround.

Boundary cases:
- Simultaneous valids in IDLE: the candidate nearest prio_ptr wins. After reset, requester 0 wins the first tie.
- A new request from the current grantee in the cycle its last beat completes is not merged. It re-arbitrates next cycle with lowest priority.
- Grantee drops valid before last: protocol violation. The grant is still held until ready & last. oreq.valid follows ireqs.valid and no response is fabricated.
- oresp.ready with valid = 0 in IDLE: ignored, no state change.
- Reset asserted mid-burst: immediate return to IDLE.
  - The memory side must also be reset.
  - No completion is delivered to the interrupted requester.
- prio_ptr wraps from NUM_REQ−1 to 0.
- busy = (state == BUSY).

Test Plan:
1. Single fetch, single beat.
   - Stimulus: after reset release, ireqs[0].valid = 1, addr 0x8000_0000, len 0. Memory returns ready & last with data 0x0000_0013 three cycles after oreq.valid.
   - Required: oreq.valid rises 1 cycle after ireqs[0].valid; iresps[0].data = 0x13 with ready & last; iresps[1] all-zero throughout; busy falls the cycle after last; prio_ptr = 1.
2. Tie and rotation.
   - Stimulus: both valid continuously; each transaction is a 4-beat burst (len = 3).
   - Required: grants alternate 0, 1, 0, 1. Each grantee receives exactly 4 ready beats, last only on beat 4. One idle cycle separates transactions.
3. No interleave.
   - Stimulus: requester 1 is granted for an 8-beat write; requester 0 asserts valid at beat 2.
   - Required: oreq carries only requester 1's addr/data/strobe until its last beat. Requester 0 is granted in the IDLE cycle after, and its request appears on oreq the following cycle.
4. Back-to-back same requester.
   - Stimulus: only ireqs[1].valid is asserted, for two consecutive transactions.
   - Required: both are served, with one idle cycle between them; grant_idx stays 1; prio_ptr = 0 after each.
5. Reset mid-burst.
   - Stimulus: assert reset during beat 2 of a 4-beat read by requester 0.
   - Required: oreq.valid = 0, busy = 0, grant_idx = 0 and prio_ptr = 0 in the same cycle, without waiting for a clock edge.
   - After release with both requesters valid: requester 0 is granted first.
6. Spurious response in IDLE.
   - Stimulus: oresp.ready = 1, last = 1 while no request is valid.
   - Required: no state change; all iresps remain zero.

Source files
------------

// File: rtl/cbus_pkg.sv
// Cache-bus request/response types shared by the arbiter and its requesters.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cache-bus port between NUM_REQ requesters.
// Whole transactions are granted; priority rotates past the grantee after each one.
module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_REQ],
    output cbus_resp_t       iresps [NUM_REQ],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   prio_ptr_q, prio_ptr_d;
    logic               cand_found;
    logic [IDX_W-1:0]   cand;

    // Scan from the farthest slot back to prio_ptr so the nearest valid one wins last.
    always_comb begin
        int idx;
        cand_found = 1'b0;
        cand       = '0;
        idx        = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(prio_ptr_q) + off) % NUM_REQ;
            if (ireqs[idx].valid) begin
                cand_found = 1'b1;
                cand       = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        prio_ptr_d = prio_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (cand_found) begin
                    state_d = StBusy;
                    grant_d = cand;
                end
            end
            StBusy: begin
                if (oresp.ready && oresp.last) begin
                    state_d    = StIdle;
                    prio_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            prio_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            prio_ptr_q <= prio_ptr_d;
        end
    end

    // Outputs depend only on state, so an asynchronous reset silences the bus at once.
    always_comb begin
        oreq   = '0;
        iresps = '{default: '0};
        if (state_q == StBusy) begin
            oreq            = ireqs[grant_q];
            iresps[grant_q] = oresp;
        end
    end

    assign busy      = (state_q == StBusy);
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench for cbus_rr_arbiter: directed scenarios plus a random phase,
// all checked every cycle against a transaction-level reference model.
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cbus_req_t              rq [N];
    cbus_resp_t             ip [N];
    cbus_req_t              oq;
    cbus_resp_t             rs;
    logic                   busy;
    logic [$clog2(N)-1:0]   gidx;

    cbus_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (rq),
        .iresps    (ip),
        .oreq      (oq),
        .oresp     (rs),
        .busy      (busy),
        .grant_idx (gidx)
    );

    // Reference model state
    bit  m_busy;
    int  m_grant, m_prio, beat, wait_cnt, done_total;
    int  pend = -1;
    // Stimulus knobs
    int  lat = -1, fixed_len = -1, arrive_pct = 0;
    int  renew_pct [N];
    bit  spurious, fixed_data;
    // Observation
    int  dut_log [$];
    bit  prev_busy;
    logic [31:0] last_data0;
    int  tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cbus_req_t new_req();
        cbus_req_t r;
        r.valid    = 1'b1;
        r.is_write = 1'($urandom_range(0, 1));
        r.size     = 2'd2;
        r.addr     = $urandom & 32'hffff_fffc;
        r.strobe   = 4'($urandom);
        r.data     = $urandom;
        r.len      = (fixed_len >= 0) ? 8'(fixed_len) : 8'($urandom_range(0, 7));
        r.burst    = 2'd1;
        return r;
    endfunction

    function automatic int draw_lat();
        return (lat >= 0) ? lat : int'($urandom_range(0, 2));
    endfunction

    task automatic check();
        cbus_req_t  eq;
        cbus_resp_t er;
        eq = m_busy ? rq[m_grant] : '0;
        chk("busy", 128'(busy), 128'(m_busy));
        chk("grant_idx", 128'(gidx), 128'(m_grant));
        chk("prio_ptr", 128'(dut.prio_ptr_q), 128'(m_prio));
        chk("oreq", 128'(oq), 128'(eq));
        for (int i = 0; i < N; i++) begin
            er = (m_busy && i == m_grant) ? rs : '0;
            chk($sformatf("iresps%0d", i), 128'(ip[i]), 128'(er));
        end
        if (ip[0].ready && ip[0].last) last_data0 = ip[0].data;
        if (busy && !prev_busy) dut_log.push_back(int'(gidx));
        prev_busy = busy;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle();
        int order [$];
        if (pend >= 0) begin
            if (int'($urandom_range(0, 99)) < renew_pct[pend]) rq[pend] = new_req();
            else rq[pend].valid = 1'b0;
            pend = -1;
        end
        for (int i = 0; i < N; i++)
            if (!rq[i].valid && int'($urandom_range(0, 99)) < arrive_pct) rq[i] = new_req();
        rs = '0;
        if (m_busy) begin
            if (wait_cnt > 0) wait_cnt--;
            else begin
                rs.ready = 1'b1;
                rs.last  = (beat == int'(rq[m_grant].len));
                rs.data  = fixed_data ? 32'h0000_0013 : $urandom;
            end
        end else if (spurious && $urandom_range(0, 1) == 1) begin
            rs.ready = 1'b1;
            rs.last  = 1'b1;
            rs.data  = $urandom;
        end
        #1 check();
        @(posedge clk);
        if (!m_busy) begin
            for (int k = 0; k < N; k++) order.push_back((m_prio + k) % N);
            foreach (order[j]) begin
                if (!m_busy && rq[order[j]].valid) begin
                    m_busy   = 1'b1;
                    m_grant  = order[j];
                    beat     = 0;
                    wait_cnt = draw_lat();
                end
            end
        end else if (rs.ready) begin
            if (rs.last) begin
                m_busy = 1'b0;
                m_prio = (m_grant + 1) % N;
                done_total++;
                pend = m_grant;
            end else begin
                beat++;
                wait_cnt = draw_lat();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        m_busy    = 1'b0;
        m_grant   = 0;
        m_prio    = 0;
        beat      = 0;
        pend      = -1;
        prev_busy = 1'b0;
        rs        = '0;
        dut_log.delete();
        #1 check();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (done_total < target && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, 128'(done_total >= target), 128'(1));
    endtask

    task automatic wait_beat(input int b);
        int n = 0;
        while (!(m_busy && beat == b) && n < 30) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        rq = '{default: '0};
        rs = '0;
        renew_pct = '{default: 0};

        // Reset state, then a single-beat fetch with 3 cycles of memory latency
        do_reset();
        rq[0] = new_req();
        rq[0].addr = 32'h8000_0000;
        rq[0].len  = 8'd0;
        lat = 3;
        fixed_data = 1'b1;
        done_total = 0;
        run_until(1, 20, "t1");
        chk("t1_busy_low", 128'(busy), 128'(0));
        chk("t1_prio", 128'(dut.prio_ptr_q), 128'(1));
        chk("t1_data", 128'(last_data0), 128'(32'h13));
        fixed_data = 1'b0;

        // Tie with continuous requests: grants alternate starting at 0
        do_reset();
        fixed_len = 3;
        lat = -1;
        renew_pct = '{default: 100};
        rq[0] = new_req();
        rq[1] = new_req();
        done_total = 0;
        run_until(4, 200, "t2");
        chk("t2_ngrants", 128'(dut_log.size()), 128'(4));
        for (int k = 0; k < 4 && k < dut_log.size(); k++)
            chk($sformatf("t2_grant%0d", k), 128'(dut_log[k]), 128'(k % 2));
        renew_pct = '{default: 0};

        // 8-beat write from requester 1; requester 0 arrives mid-burst
        do_reset();
        rq = '{default: '0};
        fixed_len = 7;
        lat = 0;
        rq[1] = new_req();
        rq[1].is_write = 1'b1;
        done_total = 0;
        wait_beat(1);
        rq[0] = new_req();
        run_until(2, 100, "t3");
        chk("t3_ngrants", 128'(dut_log.size()), 128'(2));
        if (dut_log.size() >= 2) begin
            chk("t3_first", 128'(dut_log[0]), 128'(1));
            chk("t3_second", 128'(dut_log[1]), 128'(0));
        end

        // Back-to-back transactions from requester 1 alone
        cycle();
        dut_log.delete();
        done_total = 0;
        fixed_len = -1;
        lat = -1;
        renew_pct[1] = 100;
        rq[1] = new_req();
        run_until(1, 50, "t4a");
        chk("t4_prio_a", 128'(dut.prio_ptr_q), 128'(0));
        cycle();
        renew_pct[1] = 0;
        run_until(2, 50, "t4b");
        chk("t4_prio_b", 128'(dut.prio_ptr_q), 128'(0));
        chk("t4_ngrants", 128'(dut_log.size()), 128'(2));
        if (dut_log.size() >= 2) begin
            chk("t4_g0", 128'(dut_log[0]), 128'(1));
            chk("t4_g1", 128'(dut_log[1]), 128'(1));
        end
        cycle();

        // Reset during beat 2 of a 4-beat read, then a tie after release
        do_reset();
        fixed_len = 3;
        lat = 0;
        rq = '{default: '0};
        rq[0] = new_req();
        rq[0].is_write = 1'b0;
        wait_beat(1);
        do_reset();
        chk("t5_oreq_valid", 128'(oq.valid), 128'(0));
        chk("t5_busy", 128'(busy), 128'(0));
        rq[1] = new_req();
        cycle();
        cycle();
        chk("t5_first_grant", 128'(dut_log.size() > 0 ? dut_log[0] : -1), 128'(0));
        done_total = 0;
        run_until(2, 100, "t5");

        // Spurious responses while idle
        rq = '{default: '0};
        pend = -1;
        spurious = 1'b1;
        repeat (12) cycle();
        chk("t6_busy", 128'(busy), 128'(0));

        // Random traffic
        do_reset();
        fixed_len = -1;
        lat = -1;
        arrive_pct = 30;
        renew_pct = '{default: 50};
        repeat (3000) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
